key_pio_debounced: RTL and testbench



---
 rtl/key_pio_debounced.sv | 86 ++++++++
 tb/tb_key_pio_debounced.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_pio_debounced.sv
// key_pio_debounced: Avalon-MM key/switch PIO with 2-flop sync, per-bit debounce,
// selectable rise/fall edge capture (write-1-to-clear) and a maskable IRQ.
module key_pio_debounced #(
    parameter int WIDTH = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RISE_EN_RESET = '0,
    parameter logic [WIDTH-1:0] FALL_EN_RESET = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] r_s1, r_sync, r_deb, r_deb_d, r_mask, r_cap, r_rise_en, r_fall_en;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic             w_wr;
    logic [WIDTH-1:0] w_edge, w_clr, w_wd;
    logic [31:0]      w_rd;
    logic             w_unused;

    assign w_wr     = chipselect && !write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign w_unused = &{1'b0, writedata};
    assign w_edge   = (r_deb & ~r_deb_d & r_rise_en) | (~r_deb & r_deb_d & r_fall_en);
    assign w_clr    = (w_wr && address == 3'd3) ? w_wd : '0;
    assign irq      = |(r_cap & r_mask);

    always_comb begin
        w_rd = '0;
        case (address)
            3'd0:    w_rd = 32'(r_deb);
            3'd1:    w_rd = 32'(r_sync);
            3'd2:    w_rd = 32'(r_mask);
            3'd3:    w_rd = 32'(r_cap);
            3'd4:    w_rd = 32'(r_rise_en);
            3'd5:    w_rd = 32'(r_fall_en);
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= '0;
            r_sync    <= '0;
            r_deb_d   <= '0;
            r_mask    <= '0;
            r_cap     <= '0;
            r_rise_en <= RISE_EN_RESET;
            r_fall_en <= FALL_EN_RESET;
            readdata  <= '0;
        end else begin
            r_s1     <= in_port;
            r_sync   <= r_s1;
            r_deb_d  <= r_deb;
            readdata <= w_rd;
            // a new edge beats a simultaneous clear so no event is lost
            r_cap    <= (r_cap & ~w_clr) | w_edge;
            if (w_wr && address == 3'd2) r_mask <= w_wd;
            if (w_wr && address == 3'd4) r_rise_en <= w_wd;
            if (w_wr && address == 3'd5) r_fall_en <= w_wd;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH; b++) begin
            if (reset) begin
                r_cnt[b] <= '0;
                r_deb[b] <= 1'b0;
            end else if (r_sync[b] == r_deb[b]) begin
                r_cnt[b] <= '0;
            end else if (r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_deb[b] <= r_sync[b];
                r_cnt[b] <= '0;
            end else begin
                r_cnt[b] <= r_cnt[b] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_key_pio_debounced.sv
// tb_key_pio_debounced: directed + table + randomized checks of key_pio_debounced
// against a history-window reference model.
module tb_key_pio_debounced;
    localparam int W = 4;
    localparam int N = 4;

    logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    key_pio_debounced #(
        .WIDTH(W), .DEBOUNCE_CYCLES(N), .RISE_EN_RESET(4'h0), .FALL_EN_RESET(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    // Reference: debounced bit flips once the last N synchronised samples all disagree with it.
    logic [W-1:0] m_deb, m_deb_d, m_cap, m_mask, m_rise, m_fall;
    logic [31:0]  m_rd;
    logic [W-1:0] m_pipe[$], m_hist[$];

    function automatic logic [31:0] m_read(input logic [2:0] a);
        return a == 0 ? 32'(m_deb) : a == 1 ? 32'(m_pipe[0]) : a == 2 ? 32'(m_mask) :
               a == 3 ? 32'(m_cap) : a == 4 ? 32'(m_rise) : a == 5 ? 32'(m_fall) : 32'h0;
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] e, nd, clr;
        bit all_diff;
        if (reset) begin
            m_deb = '0; m_deb_d = '0; m_cap = '0; m_mask = '0;
            m_rise = '0; m_fall = '1; m_rd = '0;
            m_pipe = '{4'h0, 4'h0};
            m_hist.delete();
            repeat (N) m_hist.push_back(4'h0);
        end else begin
            e   = (m_deb & ~m_deb_d & m_rise) | (~m_deb & m_deb_d & m_fall);
            clr = (chipselect && !write_n && address == 3) ? writedata[W-1:0] : '0;
            m_rd = m_read(address);
            m_cap = (m_cap & ~clr) | e;
            if (chipselect && !write_n) begin
                if (address == 2) m_mask = writedata[W-1:0];
                if (address == 4) m_rise = writedata[W-1:0];
                if (address == 5) m_fall = writedata[W-1:0];
            end
            m_deb_d = m_deb;
            m_hist.push_back(m_pipe[0]);
            void'(m_hist.pop_front());
            nd = m_deb;
            for (int b = 0; b < W; b++) begin
                all_diff = 1;
                foreach (m_hist[k]) if (m_hist[k][b] == m_deb[b]) all_diff = 0;
                if (all_diff) nd[b] = ~m_deb[b];
            end
            m_deb = nd;
            void'(m_pipe.pop_front());
            m_pipe.push_back(in_port);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sb_readdata", readdata, m_rd);
            chk("sb_irq", 32'(irq), 32'(|(m_cap & m_mask)));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_noirq(input int n, input string name);
        repeat (n) begin
            @(negedge clk);
            chk(name, 32'(irq), 32'h0);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[8];
        logic [31:0] v;
        for (int i = 0; i < 8; i++) tbl[i] = '{3'(i), (i == 5) ? 32'hF : 32'h0};

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk_en = 1;
        chk("rst_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].addr, v);
            chk($sformatf("rst_off%0d", tbl[i].addr), v, tbl[i].exp);
        end

        // rising edge on bit 0: deb at edge 6, capture/irq at edge 7
        wr(4, 32'h1);
        wr(2, 32'h1);
        address = 0;
        in_port[0] = 1'b1;
        tick(6);
        chk("t2_deb_pre", readdata, 32'h0);
        chk("t2_irq_pre", 32'(irq), 32'h0);
        tick(1);
        chk("t2_deb", readdata, 32'h1);
        chk("t2_irq", 32'(irq), 32'h1);
        rd(3, v);
        chk("t2_cap", v, 32'h1);
        wr(3, 32'h1);
        chk("t2_irq_clr", 32'(irq), 32'h0);
        rd(3, v);
        chk("t2_cap_clr", v, 32'h0);

        // short glitches on bit 1 must never reach deb
        wr(4, 32'h3);
        in_port[1] = 1'b1;
        tick_noirq(1, "t3_irq");
        in_port[1] = 1'b0;
        tick_noirq(10, "t3_irq");
        in_port[1] = 1'b1;
        tick_noirq(3, "t3_irq");
        in_port[1] = 1'b0;
        tick_noirq(10, "t3_irq");
        rd(0, v);
        chk("t3_deb", v, 32'h1);
        rd(3, v);
        chk("t3_cap", v, 32'h0);

        // falling-only on bit 2, W1C with 0 and with bit 2 clear
        wr(5, 32'h4);
        wr(4, 32'h0);
        in_port[2] = 1'b1;
        tick(12);
        rd(3, v);
        chk("t4_no_rise", v, 32'h0);
        in_port[2] = 1'b0;
        tick(12);
        rd(3, v);
        chk("t4_fall", v, 32'h4);
        wr(3, 32'h0);
        rd(3, v);
        chk("t4_w0", v, 32'h4);
        wr(3, 32'hB);
        rd(3, v);
        chk("t4_wB", v, 32'h4);
        chk("t4_irq", 32'(irq), 32'h0);

        // capture on bit 3 coincides with its clear write; then mask raises irq
        wr(3, 32'h4);
        wr(4, 32'h8);
        wr(2, 32'h0);
        in_port[3] = 1'b1;
        tick(6);
        wr(3, 32'h8);
        rd(3, v);
        chk("t5_set_wins", v, 32'h8);
        chk("t5_irq_masked", 32'(irq), 32'h0);
        wr(2, 32'h8);
        chk("t5_irq_mask", 32'(irq), 32'h1);

        // reset mid-debounce on bit 1 restarts everything
        wr(4, 32'hA);
        wr(3, 32'hF);
        chk("t6_irq_pre", 32'(irq), 32'h0);
        address = 0;
        in_port[1] = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_rst_rd", readdata, 32'h0);
        chk("t6_rst_irq", 32'(irq), 32'h0);
        tick(6);
        chk("t6_deb_pre", readdata, 32'h0);
        tick(1);
        chk("t6_deb", readdata, 32'hB);
        rd(3, v);
        chk("t6_cap", v, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ 4'($urandom);
            address    = 3'($urandom);
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            reset      = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        reset = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
